right_shift_pipe: RTL and testbench

RIGHT_SHIFT_PIPE -- requirements
Module: right_shift_pipe

---
 rtl/shifter_pkg.sv | 9 +
 rtl/right_shift_stage.sv | 57 +++++
 rtl/right_shift_pipe.sv | 70 +++++++
 tb/tb_right_shift_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared shifter types
package shifter_pkg;

  typedef enum logic {
    SHIFT_LOGICAL = 1'b0,
    SHIFT_ARITH   = 1'b1
  } shift_mode_e;

endpackage

// File: rtl/right_shift_stage.sv
// rtl/right_shift_stage.sv - one registered stage of the right-shift pipe
// Shifts by SHIFT when its amount bit is set, then registers data, amount, fill and valid.
module right_shift_stage
  import shifter_pkg::*;
#(
  parameter int nBITS = 32,
  parameter int AW    = 5,
  parameter int SHIFT = 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Advance,
  input  logic             i_Valid,
  input  logic [nBITS-1:0] i_Data,
  input  logic [AW-1:0]    i_Amount,
  input  logic             i_Fill,
  output logic             o_Valid,
  output logic [nBITS-1:0] o_Data,
  output logic [AW-1:0]    o_Amount,
  output logic             o_Fill
);

  localparam int BIT = $clog2(SHIFT);

  logic [nBITS-1:0] w_shifted;
  logic             r_valid;
  logic [nBITS-1:0] r_data;
  logic [AW-1:0]    r_amount;
  logic             r_fill;

  always_comb begin
    w_shifted = i_Data;
    if (i_Amount[BIT]) begin
      w_shifted = {{SHIFT{i_Fill}}, i_Data[nBITS-1:SHIFT]};
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_amount <= '0;
      r_fill   <= 1'b0;
    end else if (i_Advance) begin
      r_valid  <= i_Valid;
      r_data   <= w_shifted;
      r_amount <= i_Amount;
      r_fill   <= i_Fill;
    end
  end

  assign o_Valid  = r_valid;
  assign o_Data   = r_data;
  assign o_Amount = r_amount;
  assign o_Fill   = r_fill;

endmodule

// File: rtl/right_shift_pipe.sv
// rtl/right_shift_pipe.sv - log2(nBITS)-stage pipelined right shifter with valid/ready flow control
module right_shift_pipe
  import shifter_pkg::*;
#(
  parameter int nBITS = 32
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic [nBITS-1:0]         i_In,
  input  logic [$clog2(nBITS)-1:0] i_ShiftAmount,
  input  logic                     i_ShiftIn,
  input  logic                     i_Mode,
  input  logic                     i_InValid,
  output logic                     o_InReady,
  output logic [nBITS-1:0]         o_Out,
  output logic                     o_OutValid,
  input  logic                     i_OutReady,
  output logic                     o_Busy
);

  localparam int L = $clog2(nBITS);

  logic [L:0][nBITS-1:0] w_data;
  logic [L:0][L-1:0]     w_amt;
  logic [L:0]            w_fill;
  logic [L:0]            w_valid;
  logic                  w_advance;
  shift_mode_e           w_mode;
  logic                  w_unused_tail;

  // The whole pipe moves as one; a full output register that is not taken freezes every stage.
  assign w_advance = !w_valid[L] || i_OutReady;
  assign w_mode    = shift_mode_e'(i_Mode);

  assign w_data[0]  = i_In;
  assign w_amt[0]   = i_ShiftAmount;
  assign w_fill[0]  = (w_mode == SHIFT_ARITH) ? i_In[nBITS-1] : i_ShiftIn;
  assign w_valid[0] = i_InValid;

  generate
    for (genvar k = 0; k < L; k++) begin : g_stage
      right_shift_stage #(
        .nBITS (nBITS),
        .AW    (L),
        .SHIFT (1 << (L - 1 - k))
      ) u_stage (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Advance(w_advance),
        .i_Valid  (w_valid[k]),
        .i_Data   (w_data[k]),
        .i_Amount (w_amt[k]),
        .i_Fill   (w_fill[k]),
        .o_Valid  (w_valid[k+1]),
        .o_Data   (w_data[k+1]),
        .o_Amount (w_amt[k+1]),
        .o_Fill   (w_fill[k+1])
      );
    end
  endgenerate

  // Amount and fill are fully consumed by the last stage.
  assign w_unused_tail = ^{w_amt[L], w_fill[L]};

  assign o_InReady  = w_advance;
  assign o_Out      = w_data[L];
  assign o_OutValid = w_valid[L];
  assign o_Busy     = |w_valid[L:1];

endmodule

// File: tb/tb_right_shift_pipe.sv
// tb/tb_right_shift_pipe.sv - self-checking bench for right_shift_pipe
module tb_right_shift_pipe;

  localparam int N = 32;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in_data = '0;
  logic [L-1:0] shamt = '0;
  logic         shift_in = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;

  typedef struct {
    logic [N-1:0] d;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           lat_en = 0;
  bit           head_seen = 0;
  logic [N-1:0] hold;

  right_shift_pipe #(.nBITS(N)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_In         (in_data),
    .i_ShiftAmount(shamt),
    .i_ShiftIn    (shift_in),
    .i_Mode       (mode),
    .i_InValid    (in_valid),
    .o_InReady    (in_ready),
    .o_Out        (out_data),
    .o_OutValid   (out_valid),
    .i_OutReady   (out_ready),
    .o_Busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain shift, then force the vacated top bits to ones when the fill bit is 1.
  function automatic logic [N-1:0] model(input logic [N-1:0] d, input logic [L-1:0] sa,
                                         input logic sin, input logic md);
    logic         fill;
    logic [N-1:0] r;
    fill = md ? d[N-1] : sin;
    r = d >> sa;
    if (fill) r = r | ~({N{1'b1}} >> sa);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [N-1:0] d, input logic [L-1:0] sa,
                      input logic sin, input logic md, input logic ordy, input logic [N-1:0] e);
    in_valid  = v;
    in_data   = d;
    shamt     = sa;
    shift_in  = sin;
    mode      = md;
    out_ready = ordy;
    #1;
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        if (lat_en && !head_seen) chk("latency", cyc - q[0].acc, L);
        head_seen = 1;
        if (out_ready) begin
          chk("out_data", out_data, q[0].d);
          void'(q.pop_front());
          head_seen = 0;
        end
      end
    end
    if (v && in_ready) q.push_back('{e, cyc});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic issue_rand(input logic ordy);
    logic [N-1:0] d;
    logic [L-1:0] sa;
    logic         sin, md;
    d   = $urandom;
    sa  = L'($urandom_range(0, N - 1));
    sin = 1'($urandom);
    md  = 1'($urandom);
    step(1'b1, d, sa, sin, md, ordy, model(d, sa, sin, md));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) idle();
    repeat (6) idle();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", out_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with exact latency
    lat_en = 1;
    step(1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
    drain(20);
    step(1'b1, 32'hF000_0000, 5'd4, 1'b0, 1'b1, 1'b1, 32'hFF00_0000);
    step(1'b1, 32'h7000_0000, 5'd4, 1'b0, 1'b1, 1'b1, 32'h0700_0000);
    step(1'b1, 32'h0000_0000, 5'd8, 1'b1, 1'b0, 1'b1, 32'hFF00_0000);
    step(1'b1, 32'h1234_5678, 5'd0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    step(1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 32'h4000_0000, 5'd31, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    drain(20);

    // Five back-to-back, then a three-cycle output stall
    for (int i = 0; i < 5; i++) issue_rand(1'b1);
    chk("stall_first_valid", out_valid, 1);
    hold = out_data;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    lat_en = 0;
    chk("stall_hold", out_data, hold);
    chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, $urandom, '0, 1'b0, 1'b0, 1'b0, '0);
      chk("stall_hold", out_data, hold);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_busy", busy, 1);
    end
    drain(20);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) issue_rand(1'b1);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out", out_data, 0);
    q.delete();
    head_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) idle();
    lat_en = 1;
    issue_rand(1'b1);
    drain(20);
    lat_en = 0;

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) issue_rand(1'($urandom_range(0, 3) != 0));
      else step(1'b0, $urandom, '0, 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), '0);
    end
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
